encoded_accumulator: RTL

- Parametrised successor of the 4-input encode-and-accumulate counter.
- Samples N_IN asynchronous switch/button lines, synchronises them, and detects a press event (rising edge of "any line active").
- On each event, priority-encodes the highest active line index and adds it to an ACC_W-bit accumulator, in wrap or saturate mode.
- Drives a hex seven-segment digit per accumulator nibble, a terminal-count flag and a sticky overflow flag; sits between the board switches and the display.

---
 rtl/encoded_accumulator_pkg.sv | 59 +++++
 rtl/encoded_accumulator_if.sv | 25 ++
 rtl/encoded_accumulator_input_sync_edge.sv | 40 ++++
 rtl/encoded_accumulator.sv | 90 +++++++++
 4 files changed

// File: rtl/encoded_accumulator_pkg.sv
// ============================================================================
// Module : encoded_accumulator_pkg
// Brief  : Shared constants, mode enum, hex glyph and priority-encode helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package encoded_accumulator_pkg;

    localparam int SEG_W  = 7;
    localparam int MAX_IN = 64;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } acc_mode_e;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Index of the highest set bit among the lowest n_in bits; 0 if none set.
    function automatic int unsigned prio_enc(input logic [MAX_IN-1:0] vec,
                                             input int unsigned n_in);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_IN; i++) begin
            if (i < n_in && vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/encoded_accumulator_if.sv
// ============================================================================
// Module : encoded_accumulator_if
// Brief  : Switch inputs and display/flag outputs of the encoded accumulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface encoded_accumulator_if #(
    parameter int N_IN  = 4,
    parameter int ACC_W = 4
);
    localparam int NUM_DIG = (ACC_W + 3) / 4;

    logic [N_IN-1:0]      A;
    logic                 clr;
    logic [ACC_W-1:0]     acc;
    logic                 ovf;
    logic                 term;
    logic [7*NUM_DIG-1:0] seg;

    modport master (output A, clr, input acc, ovf, term, seg);
    modport slave  (input A, clr, output acc, ovf, term, seg);
endinterface

`default_nettype wire

// File: rtl/encoded_accumulator_input_sync_edge.sv
// ============================================================================
// Module : input_sync_edge
// Brief  : Two-flop synchroniser plus history register; flags press events.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module input_sync_edge #(
    parameter int W = 4
) (
    input  wire logic         clk,
    input  wire logic         inrst,
    input  wire logic [W-1:0] a_in,
    output logic      [W-1:0] s2,
    output logic              evt
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_s3;

    always_ff @(posedge clk or negedge inrst) begin
        if (!inrst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= a_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Event only when the group goes from idle to active, so added lines are ignored.
    assign s2  = r_s2;
    assign evt = (|r_s2) & ~(|r_s3);

endmodule

`default_nettype wire

// File: rtl/encoded_accumulator.sv
// ============================================================================
// Module : encoded_accumulator
// Brief  : Encodes highest pressed line and accumulates it; drives hex digits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module encoded_accumulator
    import encoded_accumulator_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int ACC_W    = 4,
    parameter int SAT_MODE = 0,
    parameter int TERM_VAL = 3
) (
    input  wire logic               clk,
    input  wire logic               inrst,
    encoded_accumulator_if.slave    bus
);

    localparam int IDX_W   = $clog2(N_IN);
    localparam int NUM_DIG = (ACC_W + 3) / 4;
    localparam int SUM_W   = ((ACC_W > IDX_W) ? ACC_W : IDX_W) + 1;

    localparam acc_mode_e        c_mode    = (SAT_MODE != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic [SUM_W-1:0] c_acc_max = SUM_W'((1 << ACC_W) - 1);
    localparam logic [ACC_W-1:0] c_term    = ACC_W'(TERM_VAL);

    logic [N_IN-1:0]      w_s2;
    logic                 w_evt;
    logic [IDX_W-1:0]     w_idx;
    logic [SUM_W-1:0]     w_sum;
    logic                 w_over;
    logic [ACC_W-1:0]     w_next_acc;
    logic [4*NUM_DIG-1:0] w_acc_pad;

    logic [ACC_W-1:0]     r_acc;
    logic                 r_ovf;

    input_sync_edge #(
        .W (N_IN)
    ) u_sync (
        .clk   (clk),
        .inrst (inrst),
        .a_in  (bus.A),
        .s2    (w_s2),
        .evt   (w_evt)
    );

    assign w_idx  = IDX_W'(prio_enc(MAX_IN'(w_s2), N_IN));
    assign w_sum  = SUM_W'(r_acc) + SUM_W'(w_idx);
    assign w_over = (w_sum > c_acc_max);

    always_comb begin
        w_next_acc = w_sum[ACC_W-1:0];
        if (c_mode == MODE_SAT && w_over) begin
            w_next_acc = c_acc_max[ACC_W-1:0];
        end
    end

    // Clear wins over a coincident event; that event is dropped, not queued.
    always_ff @(posedge clk or negedge inrst) begin
        if (!inrst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (bus.clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_evt) begin
            r_acc <= w_next_acc;
            if (w_over) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.acc   = r_acc;
    assign bus.ovf   = r_ovf;
    assign bus.term  = (r_acc == c_term);
    assign w_acc_pad = (4*NUM_DIG)'(r_acc);

    generate
        for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_digit
            assign bus.seg[SEG_W*gi +: SEG_W] = hex_to_seg(w_acc_pad[4*gi +: 4]);
        end
    endgenerate

endmodule

`default_nettype wire
